// File: rtl/div_8bit.sv
// div_8bit: 8-bit unsigned restoring divider, one quotient bit per clock.
// A start in IDLE captures the operands; eight CALC cycles later the result
// appears together with a one-cycle done pulse. A zero divisor skips CALC and
// reports quotient 8'hFF with the div0 flag set.
// Optional feature: define DIV_REM_EN to add the remainder output port.

module div_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
`ifdef DIV_REM_EN
  output logic [7:0] remainder,
`endif
  output logic       busy,
  output logic       done,
  output logic       div0
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] dvs;       // captured divisor
  logic [7:0] dq;        // dividend bits shifting out, quotient bits shifting in
  logic [7:0] prem;      // partial remainder
  logic [3:0] cnt;       // iteration counter

  logic [9:0] trial;
  logic [7:0] next_prem;
  logic [7:0] next_dq;

  // One restoring step: shift {prem, dq} left, trial-subtract the divisor.
  // A restored remainder always fits 8 bits because it is below the divisor.
  always_comb begin
    trial     = {1'b0, prem, dq[7]} - {2'b00, dvs};
    next_prem = {prem[6:0], dq[7]};
    next_dq   = {dq[6:0], 1'b0};
    if (!trial[9]) begin
      next_prem = trial[7:0];
      next_dq   = {dq[6:0], 1'b1};
    end
  end

  // Control FSM with registered outputs; reset wins over any start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      quotient <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div0     <= 1'b0;
      cnt      <= 4'd0;
      dvs      <= 8'd0;
      dq       <= 8'd0;
      prem     <= 8'd0;
`ifdef DIV_REM_EN
      remainder <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == 8'd0) begin
              state    <= DONE;
              quotient <= 8'hFF;
              div0     <= 1'b1;
              done     <= 1'b1;
`ifdef DIV_REM_EN
              remainder <= dividend;
`endif
            end else begin
              state <= CALC;
              dvs   <= divisor;
              dq    <= dividend;
              prem  <= 8'd0;
              cnt   <= 4'd0;
              div0  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          dq   <= next_dq;
          prem <= next_prem;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            quotient <= next_dq;
`ifdef DIV_REM_EN
            remainder <= next_prem;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
